// File: rtl/code_lock_pkg.sv
// Shared constants for the passcode entry controller: FSM encoding and key-word layout.
package code_lock_pkg;

  localparam int unsigned KEY_VALID_BIT = 4;
  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned MAX_DIGIT     = 9;

  localparam logic MODE_PROGRAM = 1'b0;
  localparam logic MODE_VERIFY  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

endpackage

// File: rtl/code_entry_ctrl_key_press_detect.sv
// Rising-edge detect on the encoder valid bit; only in-range digits produce a press.
module key_press_detect
  import code_lock_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEY_VALID_BIT:0]     key_code,
  output logic                       press_c,
  output logic [DIGIT_W-1:0]         digit_c
);

  logic prev_valid_q;
  logic prev_valid_d;

  always_comb begin
    prev_valid_d = key_code[KEY_VALID_BIT];
    digit_c      = key_code[DIGIT_W-1:0];
    press_c      = key_code[KEY_VALID_BIT] && !prev_valid_q &&
                   (key_code[DIGIT_W-1:0] <= DIGIT_W'(MAX_DIGIT));
  end

  always_ff @(posedge clk) begin
    if (rst) prev_valid_q <= 1'b0;
    else     prev_valid_q <= prev_valid_d;
  end

endmodule

// File: rtl/code_entry_ctrl.sv
// Passcode controller: buffers digit presses, then programs or verifies the stored code
// with a consecutive-failure count and a timed lockout.
module code_entry_ctrl
  import code_lock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [4:0]                      key_code,
  input  logic                            mode_sel,
  input  logic                            clear,
  output logic [4*NUM_DIGITS-1:0]         digits_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_cnt,
  output logic                            code_set,
  output logic                            unlocked,
  output logic                            error,
  output logic                            locked_out
);

  localparam int unsigned BUF_W  = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic               press_c;
  logic [DIGIT_W-1:0] digit_c;

  key_press_detect u_key_press_detect (
    .clk      (clk),
    .rst      (rst),
    .key_code (key_code),
    .press_c  (press_c),
    .digit_c  (digit_c)
  );

  state_e             state_q,      state_d;
  logic               mode_q,       mode_d;
  logic [BUF_W-1:0]   buf_q,        buf_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [BUF_W-1:0]   code_q,       code_d;
  logic               code_set_q,   code_set_d;
  logic               unlocked_q,   unlocked_d;
  logic               error_q,      error_d;
  logic               locked_out_q, locked_out_d;
  logic [FAIL_W-1:0]  fail_q,       fail_d;
  logic [LOCK_W-1:0]  lock_cnt_q,   lock_cnt_d;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    code_set_d = code_set_q;
    unlocked_d = unlocked_q;
    error_d    = 1'b0;
    fail_d     = fail_q;
    lock_cnt_d = lock_cnt_q;

    // Clear beats any press and discards a pending evaluation; lockout ignores it.
    if (clear && (state_q != ST_LOCKOUT)) begin
      state_d    = ST_IDLE;
      buf_d      = '0;
      cnt_d      = '0;
      unlocked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_c) begin
            buf_d                = '0;
            buf_d[DIGIT_W-1:0]   = digit_c;
            cnt_d                = CNT_W'(1);
            mode_d               = mode_sel;
            state_d              = (NUM_DIGITS == 1) ? ST_CHECK : ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (press_c) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
              if (CNT_W'(i) == cnt_q) buf_d[i*DIGIT_W +: DIGIT_W] = digit_c;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_DIGITS - 1)) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (mode_q == MODE_PROGRAM) begin
            if (!code_set_q || unlocked_q) begin
              code_d     = buf_q;
              code_set_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end else if (!code_set_q) begin
            error_d = 1'b1;
          end else if (buf_q == code_q) begin
            unlocked_d = 1'b1;
            fail_d     = '0;
          end else begin
            unlocked_d = 1'b0;
            error_d    = 1'b1;
            if (fail_q != FAIL_W'(MAX_FAILS)) fail_d = fail_q + FAIL_W'(1);
            if (fail_q == FAIL_W'(MAX_FAILS - 1)) begin
              state_d    = ST_LOCKOUT;
              lock_cnt_d = '0;
            end
          end
        end
        ST_LOCKOUT: begin
          if (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
            lock_cnt_d = '0;
            fail_d     = '0;
            state_d    = ST_IDLE;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    locked_out_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_PROGRAM;
      buf_q        <= '0;
      cnt_q        <= '0;
      code_q       <= '0;
      code_set_q   <= 1'b0;
      unlocked_q   <= 1'b0;
      error_q      <= 1'b0;
      locked_out_q <= 1'b0;
      fail_q       <= '0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      code_set_q   <= code_set_d;
      unlocked_q   <= unlocked_d;
      error_q      <= error_d;
      locked_out_q <= locked_out_d;
      fail_q       <= fail_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  assign digits_out = buf_q;
  assign digit_cnt  = cnt_q;
  assign code_set   = code_set_q;
  assign unlocked   = unlocked_q;
  assign error      = error_q;
  assign locked_out = locked_out_q;

endmodule
